// File: rtl/card_row_xpose.sv
// card_row_xpose
//   Row-to-column transposer for the card reader path. Collects the 12 row
//   scans of a card (9-edge first) into a 12 x COLS flop array, then replays
//   the card as one 12-bit hole word per column, column 1 first.
//   Hole word bit k holds the k-th row received:
//     bit 0..11 = rows 9,8,7,6,5,4,3,2,1,0,11,12
//
// Ports
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_row_valid  row scan present on i_row_bits
//   i_row_first  the presented row is row 9 (first of card)
//   i_row_bits   one row scan, bit 0 = column 1
//   o_row_ready  block accepts a row this cycle (FILL)
//   o_col_valid  o_holes / o_col / o_last valid (EMIT)
//   i_col_ready  downstream takes the presented column this cycle
//   o_holes      12-bit hole word for the presented column
//   o_col        0-based column index
//   o_last       presented column is COLS-1
//   o_seq_err    one-cycle pulse on a row protocol violation
//   o_busy       card in progress (rows collected or emitting)
module card_row_xpose #(
  parameter int unsigned COLS = 80
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_row_valid,
  input  logic            i_row_first,
  input  logic [COLS-1:0] i_row_bits,
  output logic            o_row_ready,
  output logic            o_col_valid,
  input  logic            i_col_ready,
  output logic [11:0]     o_holes,
  output logic [6:0]      o_col,
  output logic            o_last,
  output logic            o_seq_err,
  output logic            o_busy
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  localparam int unsigned IDXW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);

  logic [COLS-1:0] mem [12];

  logic [0:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [6:0]  ptr_q, ptr_d;
  logic        accept;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        seq_err_d;
  logic [11:0] holes_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    seq_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = count_q;
    accept    = i_row_valid & (state_q == ST_FILL);

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (i_row_first) begin
            // A first row always restarts the card; flag it if one was in progress.
            wr_en     = 1'b1;
            wr_idx    = 4'd0;
            count_d   = 4'd1;
            seq_err_d = (count_q != 4'd0);
          end else if (count_q == 4'd0) begin
            seq_err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (count_q == 4'd11) begin
              count_d = 4'd0;
              state_d = ST_EMIT;
              ptr_d   = '0;
            end else begin
              count_d = count_q + 4'd1;
            end
          end
        end
      end
      ST_EMIT: begin
        if (i_col_ready) begin
          if (ptr_q == LAST_COL) begin
            state_d = ST_FILL;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 7'd1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Output word is looked up from the next pointer so it is registered along
  // with o_col. On the cycle the 12th row lands the array does not hold it
  // yet, so bit 11 of column 0 is taken straight from the incoming row.
  always_comb begin
    holes_d = '0;
    if (state_d == ST_EMIT) begin
      for (int unsigned k = 0; k < 12; k++) begin
        holes_d[k] = mem[k][ptr_d[IDXW-1:0]];
      end
      if (state_q == ST_FILL) begin
        holes_d[11] = i_row_bits[0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      ptr_q       <= '0;
      o_row_ready <= 1'b1;
      o_col_valid <= 1'b0;
      o_holes     <= '0;
      o_col       <= '0;
      o_last      <= 1'b0;
      o_seq_err   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      o_row_ready <= (state_d == ST_FILL);
      o_col_valid <= (state_d == ST_EMIT);
      o_holes     <= holes_d;
      o_col       <= (state_d == ST_EMIT) ? ptr_d : '0;
      o_last      <= (state_d == ST_EMIT) && (ptr_d == LAST_COL);
      o_seq_err   <= seq_err_d;
      o_busy      <= (state_d == ST_EMIT) || (count_d != 4'd0);
    end
  end

  // Card image: no reset, every card rewrites all 12 rows before emitting.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_idx] <= i_row_bits;
    end
  end

endmodule

// File: tb/tb_card_row_xpose.sv
// tb_card_row_xpose
//   Directed bench for card_row_xpose (COLS = 80): reset state, full card,
//   backpressure, restart, orphan row, emit lockout and reset mid-emit.
module tb_card_row_xpose;

  localparam int COLS = 80;

  logic            clk = 1'b0;
  logic            reset;
  logic            row_valid;
  logic            row_first;
  logic [COLS-1:0] row_bits;
  logic            row_ready;
  logic            col_valid;
  logic            col_ready;
  logic [11:0]     holes;
  logic [6:0]      col;
  logic            last;
  logic            seq_err;
  logic            busy;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  logic [COLS-1:0] rows [12];

  card_row_xpose #(.COLS(COLS)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_row_valid (row_valid),
    .i_row_first (row_first),
    .i_row_bits  (row_bits),
    .o_row_ready (row_ready),
    .o_col_valid (col_valid),
    .i_col_ready (col_ready),
    .o_holes     (holes),
    .o_col       (col),
    .o_last      (last),
    .o_seq_err   (seq_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLS-1:0] rnd_row();
    return COLS'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Expected hole word: bit k = column c of the k-th row sent.
  function automatic logic [11:0] col_word(input int c);
    logic [11:0] w;
    for (int k = 0; k < 12; k++) w[k] = rows[k][c];
    return w;
  endfunction

  task automatic send_row(input logic [COLS-1:0] b, input logic f);
    row_valid = 1'b1;
    row_first = f;
    row_bits  = b;
    tick();
    row_valid = 1'b0;
    row_first = 1'b0;
  endtask

  task automatic send_card;
    for (int k = 0; k < 12; k++) send_row(rows[k], k == 0);
  endtask

  task automatic new_card;
    for (int k = 0; k < 12; k++) rows[k] = rnd_row();
  endtask

  task automatic drain_full(input string tag);
    col_ready = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      chk({tag, "_valid"}, 32'(col_valid), 32'd1);
      chk({tag, "_col"},   32'(col),       32'(c));
      chk({tag, "_holes"}, 32'(holes),     32'(col_word(c)));
      chk({tag, "_last"},  32'(last),      32'(c == COLS - 1));
      tick();
    end
    chk({tag, "_end_valid"}, 32'(col_valid), 32'd0);
    chk({tag, "_end_ready"}, 32'(row_ready), 32'd1);
    chk({tag, "_end_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    int              cyc;
    int              exp_ptr;
    logic [COLS-1:0] next0;

    reset     = 1'b1;
    row_valid = 1'b0;
    row_first = 1'b0;
    row_bits  = '0;
    col_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_row_ready", 32'(row_ready), 32'd1);
    chk("rst_col_valid", 32'(col_valid), 32'd0);
    chk("rst_holes",     32'(holes),     32'd0);
    chk("rst_col",       32'(col),       32'd0);
    chk("rst_last",      32'(last),      32'd0);
    chk("rst_seq_err",   32'(seq_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);

    // Full card: col 1 rows 12 and 1, col 80 row 0
    for (int k = 0; k < 12; k++) rows[k] = '0;
    rows[11][0]  = 1'b1;
    rows[8][0]   = 1'b1;
    rows[9][79]  = 1'b1;
    col_ready = 1'b1;
    send_row(rows[0], 1'b1);
    chk("full_busy_row1", 32'(busy), 32'd1);
    for (int k = 1; k < 12; k++) send_row(rows[k], 1'b0);
    chk("full_row_ready_n1", 32'(row_ready), 32'd0);
    for (int c = 0; c < COLS; c++) begin
      chk("full_valid", 32'(col_valid), 32'd1);
      chk("full_col",   32'(col),       32'(c));
      chk("full_holes", 32'(holes),     (c == 0) ? 32'h900 : (c == 79) ? 32'h200 : 32'h000);
      chk("full_last",  32'(last),      32'(c == 79));
      tick();
    end
    chk("full_end_valid", 32'(col_valid), 32'd0);
    chk("full_end_ready", 32'(row_ready), 32'd1);
    chk("full_end_busy",  32'(busy),      32'd0);

    // Orphan row at count 0
    send_row(rnd_row(), 1'b0);
    chk("orphan_seq_err", 32'(seq_err),   32'd1);
    chk("orphan_busy",    32'(busy),      32'd0);
    chk("orphan_ready",   32'(row_ready), 32'd1);
    tick();
    chk("orphan_seq_err_off", 32'(seq_err), 32'd0);
    chk("orphan_busy_off",    32'(busy),    32'd0);

    // Backpressure: ready toggles every cycle, starting high
    new_card();
    send_card();
    col_ready = 1'b1;
    cyc = 0;
    exp_ptr = 0;
    while (col_valid && cyc < 400) begin
      chk("bp_col",   32'(col),   32'(exp_ptr));
      chk("bp_holes", 32'(holes), 32'(col_word(exp_ptr)));
      chk("bp_last",  32'(last),  32'(exp_ptr == COLS - 1));
      if (col_ready) exp_ptr++;
      tick();
      col_ready = ~col_ready;
      cyc++;
    end
    chk("bp_cycles", 32'(cyc),     32'd159);
    chk("bp_taken",  32'(exp_ptr), 32'(COLS));

    // Restart: 5 rows of one card, then a first row of a new card
    new_card();
    for (int k = 0; k < 5; k++) send_row(rows[k], k == 0);
    new_card();
    send_row(rows[0], 1'b1);
    chk("restart_seq_err", 32'(seq_err), 32'd1);
    chk("restart_busy",    32'(busy),    32'd1);
    tick();
    chk("restart_seq_err_off", 32'(seq_err), 32'd0);
    for (int k = 1; k < 11; k++) send_row(rows[k], 1'b0);
    chk("restart_not_yet_valid", 32'(col_valid), 32'd0);
    chk("restart_not_yet_ready", 32'(row_ready), 32'd1);
    send_row(rows[11], 1'b0);
    drain_full("restart");

    // Emit lockout: row_valid held high during EMIT
    new_card();
    send_card();
    next0     = rnd_row();
    row_valid = 1'b1;
    row_first = 1'b1;
    row_bits  = next0;
    col_ready = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      chk("lock_ready",   32'(row_ready), 32'd0);
      chk("lock_seq_err", 32'(seq_err),   32'd0);
      chk("lock_col",     32'(col),       32'(c));
      chk("lock_holes",   32'(holes),     32'(col_word(c)));
      tick();
    end
    chk("lock_after_ready", 32'(row_ready), 32'd1);
    chk("lock_after_valid", 32'(col_valid), 32'd0);
    chk("lock_after_busy",  32'(busy),      32'd0);
    tick();
    row_valid = 1'b0;
    row_first = 1'b0;
    chk("lock_accept_busy",    32'(busy),    32'd1);
    chk("lock_accept_seq_err", 32'(seq_err), 32'd0);
    rows[0] = next0;
    for (int k = 1; k < 12; k++) begin
      rows[k] = rnd_row();
      send_row(rows[k], 1'b0);
    end

    // Reset mid-emit at column 40
    col_ready = 1'b1;
    chk("rme_col0_holes", 32'(holes), 32'(col_word(0)));
    cyc = 0;
    while (!(col_valid && col == 7'd40) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("rme_reached_col40", 32'(col), 32'd40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rme_valid", 32'(col_valid), 32'd0);
    chk("rme_busy",  32'(busy),      32'd0);
    chk("rme_ready", 32'(row_ready), 32'd1);
    chk("rme_holes", 32'(holes),     32'd0);
    chk("rme_col",   32'(col),       32'd0);
    chk("rme_last",  32'(last),      32'd0);
    new_card();
    send_card();
    drain_full("post_reset");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/card_row_xpose.md
# card_row_xpose

Row-to-column transposer for the card reader path. The reader delivers a card as 12 row scans of COLS bits each, 9-edge first. This block stores the full card image and replays it as one 12-bit hole word per column, column 1 first. The output feeds the hole-to-EBCDIC translator directly, using the same bit assignment: row 9 = bit 0 … row 12 = bit 11.

## Interface
Parameters:
- COLS, 80, columns per card (1..128)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_row_valid  in  1  row scan present on i_row_bits
- i_row_first  in  1  qualifies i_row_valid: this row is row 9 (first of card)
- i_row_bits  in  COLS  one row; bit 0 = column 1
- o_row_ready  out  1  block accepts a row this cycle
- o_col_valid  out  1  o_holes/o_col valid
- i_col_ready  in  1  downstream takes column this cycle
- o_holes  out  12  hole word; bit k = k-th row received (9,8,7,6,5,4,3,2,1,0,11,12)
- o_col  out  7  column index, 0-based
- o_last  out  1  o_col == COLS-1 while o_col_valid
- o_seq_err  out  1  one-cycle pulse: row protocol violation
- o_busy  out  1  card in progress (row count ≠ 0 or emitting)

## Operation
- Storage: 12 × COLS flop array; row k written whole on acceptance.
- Row accept: i_row_valid & o_row_ready.
- Row counter 0..11.
- States:
  - FILL: o_row_ready=1.
  - EMIT: o_row_ready=0.
- FILL rules:
  - Accepted row with i_row_first: stored as row 0, count←1. If count was ≠0, additionally pulse o_seq_err; the partial card is discarded, so this is a restart.
  - Accepted row without i_row_first, count=0: dropped, o_seq_err pulse, count stays 0.
  - Accepted row without i_row_first, count 1..10: stored at index count, count+1.
  - Accepted row at count=11: stored, count←0, state←EMIT, column pointer←0.
- EMIT:
  - o_col_valid=1; o_holes = {row11..row0} bits at column pointer.
  - On i_col_ready: pointer+1, or if o_last go to FILL.
  - Outputs hold stable while valid & !ready.
- Inputs ignored in EMIT; i_row_valid there is not an error.
- o_busy = (state==EMIT) | (count≠0).

## Timing
- Reset values:
  - state FILL, count 0, pointer 0
  - o_row_ready=1
  - o_col_valid=0, o_holes=0, o_col=0, o_last=0
  - o_seq_err=0, o_busy=0
- Flop array contents are not reset; every card fully overwrites them.
- Outputs are registered.
- 12th row accepted at cycle n:
  - o_row_ready=0 at n+1.
  - o_col_valid=1 with column 0 at n+1.
- Throughput: one column per cycle with i_col_ready held high. A card drains in COLS cycles.
- Last column accepted at cycle m:
  - o_col_valid=0 and o_row_ready=1 at m+1.
  - A row may be accepted at m+1.
- o_seq_err asserts the cycle after the offending acceptance, for exactly 1 cycle.
- Reset mid-card or mid-emit: next cycle all outputs at reset values; the partial card is lost.
- COLS=1: o_last=1 on the single column.

## Test plan
- Full card, ready tied high:
  - Stimulus: column 1 punched in rows 12 and 1, column 80 punched in row 0 only, others blank.
  - Expect o_holes=0x900 at col 0, 0x000 for cols 1..78, 0x200 with o_last=1 at col 79.
  - Expect o_col_valid high for exactly 80 consecutive cycles starting one cycle after the 12th row.
- Backpressure:
  - Stimulus: toggle i_col_ready 1/0 every cycle.
  - Expect each column presented unchanged until taken and none skipped or duplicated. The card drains in 159 cycles.
- Restart:
  - Stimulus: 5 rows, then a row with i_row_first.
  - Expect an o_seq_err pulse and the count restarted at 1. After 11 more rows the output reflects only the new card.
- Orphan row:
  - Stimulus: row without i_row_first at count=0.
  - Expect an o_seq_err pulse, the row dropped, o_busy staying 0.
- Emit lockout:
  - Stimulus: i_row_valid held high during EMIT.
  - Expect o_row_ready=0 and no error. The first row after o_last is accepted the cycle after it.
- Reset mid-emit:
  - Stimulus: assert i_reset at column 40.
  - Expect o_col_valid=0 and o_busy=0 next cycle. A following full card emits correctly from column 0.
